bf16_reduce_seq: RTL

BF16_REDUCE_SEQ -- requirements
Module: bf16_reduce_seq

---
 rtl/bf16_pkg.sv | 22 ++
 rtl/bf16_reduce_seq_if.sv | 31 +++
 rtl/bf16_reduce_seq_add.sv | 127 ++++++++++++
 rtl/bf16_reduce_seq.sv | 104 ++++++++++
 4 files changed

// File: rtl/bf16_pkg.sv
// Shared types and constants for the bf16 sequential reduction block.
//   state_e      : reduction controller states
//   bf16_flags_t : adder exception flags (overflow, underflow, invalid)
package bf16_pkg;

  localparam logic [15:0] BF16_ZERO = 16'h0000;
  localparam logic [15:0] BF16_QNAN = 16'h7FC0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_IN  = 2'd1,
    ST_ADD_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic invalid;
  } bf16_flags_t;

endpackage

// File: rtl/bf16_reduce_seq_if.sv
// Handshake bundle of bf16_reduce_seq.
//   start/count           : job request (count latched on the start edge)
//   in_valid/in_ready/in_data : element stream
//   out_valid/out_ready/out_data/out_* : result and sticky flags
//   busy                  : block is not idle
interface bf16_reduce_seq_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] count;
  logic             in_valid;
  logic [15:0]      in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic             out_overflow;
  logic             out_underflow;
  logic             out_invalid;
  logic             busy;

  modport master (
    output start, count, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_overflow, out_underflow, out_invalid, busy
  );

  modport slave (
    input  start, count, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_overflow, out_underflow, out_invalid, busy
  );
endinterface

// File: rtl/bf16_reduce_seq_add.sv
// add_bf16: bf16 adder, round-to-nearest-even, subnormal aware.
//   clk, nRST (sync, active-low) ; bf1_in, bf2_in : operands
//   bf_out, overflow, underflow, invalid : result, valid LAT edges after operands settle
module add_bf16
  import bf16_pkg::*;
#(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [15:0] bf1_in,
  input  logic [15:0] bf2_in,
  output logic [15:0] bf_out,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);
  localparam int unsigned STAGES = (LAT > 1) ? LAT - 1 : 0;

  logic        a_nan, b_nan, a_inf, b_inf, sub, st, inc, inexact;
  logic [15:0] big, sml, rnd, res_c;
  logic [8:0]  e_big, e_sml, e_r, e_fld, d;
  logic [10:0] m_big, m_sml, m_sh, mask;
  logic [11:0] s;
  bf16_flags_t flg_c;

  // Magnitude-ordered align / add / normalise / round; bits [2:0] of s are guard, round, sticky.
  always_comb begin
    res_c = BF16_ZERO;
    flg_c = '0;
    mask  = '0;
    a_nan = (bf1_in[14:7] == 8'hFF) && (bf1_in[6:0] != 7'd0);
    b_nan = (bf2_in[14:7] == 8'hFF) && (bf2_in[6:0] != 7'd0);
    a_inf = (bf1_in[14:7] == 8'hFF) && (bf1_in[6:0] == 7'd0);
    b_inf = (bf2_in[14:7] == 8'hFF) && (bf2_in[6:0] == 7'd0);
    if (bf1_in[14:0] >= bf2_in[14:0]) begin
      big = bf1_in;
      sml = bf2_in;
    end else begin
      big = bf2_in;
      sml = bf1_in;
    end
    sub   = big[15] ^ sml[15];
    e_big = (big[14:7] == 8'd0) ? 9'd1 : {1'b0, big[14:7]};
    e_sml = (sml[14:7] == 8'd0) ? 9'd1 : {1'b0, sml[14:7]};
    m_big = {(big[14:7] != 8'd0), big[6:0], 3'b000};
    m_sml = {(sml[14:7] != 8'd0), sml[6:0], 3'b000};
    d     = e_big - e_sml;
    if (d >= 9'd11) begin
      m_sh = 11'd0;
      st   = |m_sml;
    end else begin
      m_sh = m_sml >> d;
      mask = (11'd1 << d) - 11'd1;
      st   = |(m_sml & mask);
    end
    m_sh[0] = m_sh[0] | st;
    s   = sub ? ({1'b0, m_big} - {1'b0, m_sh}) : ({1'b0, m_big} + {1'b0, m_sh});
    e_r = e_big;
    if (s[11]) begin
      s   = {1'b0, s[11:2], s[1] | s[0]};
      e_r = e_r + 9'd1;
    end
    for (int i = 0; i < 11; i++) begin
      if (!s[10] && (e_r > 9'd1)) begin
        s   = s << 1;
        e_r = e_r - 9'd1;
      end
    end
    inexact = |s[2:0];
    inc     = s[2] & (s[1] | s[0] | s[3]);
    // Exponent field 0 for subnormals; the rounding carry then ripples into the exponent naturally.
    e_fld   = s[10] ? e_r : 9'd0;
    rnd     = {e_fld, s[9:3]} + 16'(inc);

    if (a_nan || b_nan) begin
      res_c = BF16_QNAN;
    end else if (a_inf && b_inf && (bf1_in[15] != bf2_in[15])) begin
      res_c         = BF16_QNAN;
      flg_c.invalid = 1'b1;
    end else if (a_inf) begin
      res_c = bf1_in;
    end else if (b_inf) begin
      res_c = bf2_in;
    end else if (s == 12'd0) begin
      res_c = {(sub ? 1'b0 : big[15]), 15'd0};
    end else if (rnd[15:7] >= 9'd255) begin
      res_c          = {big[15], 8'hFF, 7'd0};
      flg_c.overflow = 1'b1;
    end else begin
      res_c           = {big[15], rnd[14:0]};
      flg_c.underflow = (rnd[14:7] == 8'd0) && inexact;
    end
  end

  // Output delay line so the result lands exactly LAT edges after the operands.
  if (STAGES == 0) begin : g_comb
    assign bf_out    = res_c;
    assign overflow  = flg_c.overflow;
    assign underflow = flg_c.underflow;
    assign invalid   = flg_c.invalid;
  end else begin : g_pipe
    logic [15:0] res_q [STAGES];
    bf16_flags_t flg_q [STAGES];

    always_ff @(posedge clk) begin
      if (!nRST) begin
        for (int i = 0; i < int'(STAGES); i++) begin
          res_q[i] <= '0;
          flg_q[i] <= '0;
        end
      end else begin
        res_q[0] <= res_c;
        flg_q[0] <= flg_c;
        for (int i = 1; i < int'(STAGES); i++) begin
          res_q[i] <= res_q[i-1];
          flg_q[i] <= flg_q[i-1];
        end
      end
    end

    assign bf_out    = res_q[STAGES-1];
    assign overflow  = flg_q[STAGES-1].overflow;
    assign underflow = flg_q[STAGES-1].underflow;
    assign invalid   = flg_q[STAGES-1].invalid;
  end
endmodule

// File: rtl/bf16_reduce_seq.sv
// bf16_reduce_seq: sums `count` bf16 elements one at a time through add_bf16.
//   clk, RST (sync, active-high) ; bus : bf16_reduce_seq_if.slave handshake bundle
module bf16_reduce_seq
  import bf16_pkg::*;
#(
  parameter int unsigned ADD_LAT = 2,
  parameter int unsigned CNT_W   = 8
) (
  input logic              clk,
  input logic              RST,
  bf16_reduce_seq_if.slave bus
);
  localparam int unsigned LAT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT + 1) : 1;

  state_e           state_q, state_d;
  logic [15:0]      acc_q, acc_d, op_a_q, op_a_d, op_b_q, op_b_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  bf16_flags_t      sticky_q, sticky_d, add_flg;
  logic [15:0]      sum;

  add_bf16 #(.LAT(ADD_LAT)) u_add (
    .clk       (clk),
    .nRST      (~RST),
    .bf1_in    (op_a_q),
    .bf2_in    (op_b_q),
    .bf_out    (sum),
    .overflow  (add_flg.overflow),
    .underflow (add_flg.underflow),
    .invalid   (add_flg.invalid)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    remaining_d = remaining_q;
    lat_d       = lat_q;
    sticky_d    = sticky_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          remaining_d = bus.count;
          acc_d       = BF16_ZERO;
          sticky_d    = '0;
          state_d     = (bus.count == '0) ? ST_DONE : ST_WAIT_IN;
        end
      end
      ST_WAIT_IN: begin
        if (bus.in_valid) begin
          op_a_d  = acc_q;
          op_b_d  = bus.in_data;
          lat_d   = LAT_W'(ADD_LAT);
          state_d = ST_ADD_WAIT;
        end
      end
      ST_ADD_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        // Last wait cycle: the adder result is valid now.
        if (lat_q == LAT_W'(1)) begin
          acc_d       = sum;
          sticky_d    = sticky_q | add_flg;
          remaining_d = remaining_q - CNT_W'(1);
          state_d     = (remaining_q == CNT_W'(1)) ? ST_DONE : ST_WAIT_IN;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      remaining_q <= '0;
      lat_q       <= '0;
      sticky_q    <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      remaining_q <= remaining_d;
      lat_q       <= lat_d;
      sticky_q    <= sticky_d;
    end
  end

  // All outputs are decodes of flops.
  assign bus.in_ready      = (state_q == ST_WAIT_IN);
  assign bus.out_valid     = (state_q == ST_DONE);
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.out_data      = acc_q;
  assign bus.out_overflow  = sticky_q.overflow;
  assign bus.out_underflow = sticky_q.underflow;
  assign bus.out_invalid   = sticky_q.invalid;
endmodule
